fetch_branch_predictor: RTL and testbench
=========================================

// Module: fetch_branch_predictor
// PURPOSE
//  Dynamic branch predictor feeding the fetch next-PC selector. It returns br_pred_taken for
//  the branch in fetch and trains on the execute-stage resolution (br_taken).
//  Implements a bimodal table of 2-bit saturating counters, with an optional gshare index and
//  performance counters. It sits between fetch (lookup) and execute (update).
// PARAMETERS
//  ENTRIES    32  number of 2-bit counters; power of two, >= 4
//  GHR_BITS   5   global-history width; must be <= log2(ENTRIES)
//  CNT_W      32  width of each performance counter
// PORTS
//  clk             in   1         single clock, rising edge
//  rst_n           in   1         reset, asynchronous, active-low
//  bp_enable       in   1         0 forces prediction to not-taken; training continues
//  f_valid         in   1         fetch lookup valid
//  f_pc            in   32        fetch PC of the branch being predicted
//  br_pred_taken   out  1         prediction for f_pc (combinational)
//  f_ghr           out  GHR_BITS  history snapshot used for this lookup; piped to execute
//  x_valid         in   1         resolved conditional branch in execute this cycle
//  x_pc            in   32        PC of the resolved branch
//  x_taken         in   1         actual outcome (br_taken)
//  x_pred_taken    in   1         prediction that was made for it (piped from fetch)
//  x_ghr           in   GHR_BITS  f_ghr piped alongside the branch
//  x_mispredict    out  1         x_valid & (x_taken != x_pred_taken) (combinational)
//  perf_branches   out  CNT_W     resolved-branch count
//  perf_mispred    out  CNT_W     mispredict count
// BEHAVIOUR
//  - Index: IW = log2(ENTRIES); idx(pc, h) = pc[IW+1:2], or with gshare the same bits XOR
//    {0, h}. PC bits [1:0] are ignored.
//  - Lookup (0 latency): br_pred_taken = bp_enable & f_valid & table[idx(f_pc, ghr)][1].
//    f_ghr = ghr.
//  - Update: registered; takes effect at the clk edge when x_valid is high, using
//    idx(x_pc, x_ghr).
//    - Counter taken: 00->01->10->11, holds at 11.
//    - Counter not-taken: 11->10->01->00, holds at 00.
//  - Same-cycle lookup and update to the same index: the lookup sees the pre-update value.
//    There is no bypass.
//  - GHR: on x_valid, ghr <= {ghr[GHR_BITS-2:0], x_taken}. History is non-speculative
//    (resolution order).
//  - Perf counters:
//    - perf_branches += 1 on x_valid.
//    - perf_mispred += 1 on x_mispredict.
//    - Both wrap modulo 2^CNT_W; this is intentional, and software takes differences.
//  - Reset (async assert, sync deassert external):
//    - every counter = 2'b01 (weakly not-taken); ghr = 0; perf counters = 0.
//    - Hence br_pred_taken = 0, f_ghr = 0, x_mispredict follows its inputs.
//    - Reset mid-training discards all state immediately.
//  - bp_enable=0 clamps only the prediction output; table, ghr and perf still update on
//    x_valid.
//  - x_valid with X on x_pc is illegal; when x_valid=0, x_* inputs are don't-care.
// CONFIGURATION
//  - BP_GSHARE_EN defined: index = pc bits XOR zero-extended history; ghr register present.
//  - BP_GSHARE_EN undefined: pure bimodal index; ghr is not built, f_ghr ties to 0, and
//    x_ghr is ignored. Ports stay present so the pipeline wiring is identical.
// STRUCTURE
//  - Shared include bp_defs.vh: counter encodings BP_SNT=2'b00, BP_WNT=2'b01, BP_WT=2'b10,
//    BP_ST=2'b11; reset value BP_CTR_RESET=BP_WNT.
//  - Sub-module bp_sat_ctr2: purely combinational next-state of one 2-bit counter
//    (ctr, taken -> ctr_nxt). Instantiated once on the update path.
//  - Table is a flop array (async reset required); no SRAM macro.
// TESTING
//  1. Reset then lookup f_pc=0x4000_0000 -> br_pred_taken=0, f_ghr=0, perf_*=0.
//  2. Two updates x_pc=0x4000_0010 taken (01->10->11) -> lookup 0x4000_0010 predicts 1;
//     one not-taken (11->10) still predicts 1; a second (10->01) predicts 0.
//  3. Saturation: five taken updates then one not-taken on 0x4000_0020 -> predict 1
//     (11->10). Five not-taken then one taken -> predict 0.
//  4. Aliasing/wrap: with ENTRIES=32, train 0x4000_0004 taken twice -> 0x4000_0084 (same
//     index, bimodal) predicts 1.
//  5. Same-cycle lookup+update on one index at WNT with x_taken=1 -> lookup returns 0 that
//     cycle and 1 the next. Also bp_enable=0 with counter at 11 -> 0, table still trains.
//  6. Perf: 10 updates, 3 with x_taken!=x_pred_taken -> perf_branches=10, perf_mispred=3.
//     Preload CNT_W=4 to 15 and update once -> wraps to 0. Assert rst_n mid-sequence ->
//     all state returns to reset values asynchronously.
//  Run 1-6 with and without BP_GSHARE_EN. With gshare, 4 checks that differing ghr values
//  break the alias.

Source files
------------

// File: rtl/fetch_branch_predictor_pkg.sv
// Shared definitions for the fetch branch predictor: 2-bit counter encodings and reset value.
package fetch_branch_predictor_pkg;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_SNT       = 2'b00;
  localparam bp_ctr_t BP_WNT       = 2'b01;
  localparam bp_ctr_t BP_WT        = 2'b10;
  localparam bp_ctr_t BP_ST        = 2'b11;
  localparam bp_ctr_t BP_CTR_RESET = BP_WNT;

endpackage

// File: rtl/fetch_branch_predictor_bp_sat_ctr2.sv
// Combinational next state of one 2-bit saturating counter.
module bp_sat_ctr2
  import fetch_branch_predictor_pkg::*;
(
  input  bp_ctr_t ctr,
  input  logic    taken,
  output bp_ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != BP_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != BP_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/fetch_branch_predictor.sv
// Bimodal 2-bit-counter branch predictor with performance counters.
// Define BP_GSHARE_EN to XOR the global history into the table index.
module fetch_branch_predictor
  import fetch_branch_predictor_pkg::*;
#(
  parameter int ENTRIES  = 32,
  parameter int GHR_BITS = 5,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bp_enable,
  input  logic                f_valid,
  input  logic [31:0]         f_pc,
  output logic                br_pred_taken,
  output logic [GHR_BITS-1:0] f_ghr,
  input  logic                x_valid,
  input  logic [31:0]         x_pc,
  input  logic                x_taken,
  input  logic                x_pred_taken,
  input  logic [GHR_BITS-1:0] x_ghr,
  output logic                x_mispredict,
  output logic [CNT_W-1:0]    perf_branches,
  output logic [CNT_W-1:0]    perf_mispred
);

  localparam int IW = $clog2(ENTRIES);

  logic [ENTRIES-1:0][1:0] ctr_arr;
  logic [IW-1:0]           f_idx;
  logic [IW-1:0]           x_idx;
  logic [GHR_BITS-1:0]     ghr;
  bp_ctr_t                 ctr_cur;
  bp_ctr_t                 ctr_next;
  logic [CNT_W-1:0]        perf_branches_reg;
  logic [CNT_W-1:0]        perf_mispred_reg;

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_reg;

  // History advances in resolution order only, never speculatively.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_reg <= '0;
    end else if (x_valid) begin
      ghr_reg <= {ghr_reg[GHR_BITS-2:0], x_taken};
    end
  end

  assign ghr   = ghr_reg;
  assign f_idx = f_pc[IW+1:2] ^ IW'(ghr);
  assign x_idx = x_pc[IW+1:2] ^ IW'(x_ghr);
`else
  logic unused_ghr;
  assign unused_ghr = &{1'b0, x_ghr};
  assign ghr   = '0;
  assign f_idx = f_pc[IW+1:2];
  assign x_idx = x_pc[IW+1:2];
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, f_pc[1:0], f_pc[31:IW+2], x_pc[1:0], x_pc[31:IW+2]};

  assign ctr_cur = ctr_arr[x_idx];

  bp_sat_ctr2 u_sat_ctr2 (
    .ctr      (ctr_cur),
    .taken    (x_taken),
    .ctr_next (ctr_next)
  );

  // Flop-based table so every entry can reset asynchronously.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : gen_tbl
      bp_ctr_t ctr_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctr_reg <= BP_CTR_RESET;
        end else if (x_valid && (x_idx == IW'(gi))) begin
          ctr_reg <= ctr_next;
        end
      end

      assign ctr_arr[gi] = ctr_reg;
    end
  endgenerate

  // Lookup reads the pre-update table; no bypass from the update path.
  assign br_pred_taken = bp_enable & f_valid & ctr_arr[f_idx][1];
  assign f_ghr         = ghr;
  assign x_mispredict  = x_valid & (x_taken ^ x_pred_taken);

  // Counters wrap freely; software works with differences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches_reg <= '0;
      perf_mispred_reg  <= '0;
    end else begin
      if (x_valid)      perf_branches_reg <= perf_branches_reg + CNT_W'(1);
      if (x_mispredict) perf_mispred_reg  <= perf_mispred_reg + CNT_W'(1);
    end
  end

  assign perf_branches = perf_branches_reg;
  assign perf_mispred  = perf_mispred_reg;

endmodule

// File: tb/tb_fetch_branch_predictor.sv
// Directed self-checking bench for fetch_branch_predictor (bimodal or, with BP_GSHARE_EN, gshare).
module tb_fetch_branch_predictor;

  localparam int ENTRIES  = 32;
  localparam int GHR_BITS = 5;
  localparam int CNT_W    = 4;
`ifdef BP_GSHARE_EN
  localparam bit GSHARE = 1'b1;
`else
  localparam bit GSHARE = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                bp_enable = 1'b1;
  logic                f_valid = 1'b0;
  logic [31:0]         f_pc = '0;
  logic                br_pred_taken;
  logic [GHR_BITS-1:0] f_ghr;
  logic                x_valid = 1'b0;
  logic [31:0]         x_pc = '0;
  logic                x_taken = 1'b0;
  logic                x_pred_taken = 1'b0;
  logic [GHR_BITS-1:0] x_ghr = '0;
  logic                x_mispredict;
  logic [CNT_W-1:0]    perf_branches;
  logic [CNT_W-1:0]    perf_mispred;

  fetch_branch_predictor #(
    .ENTRIES  (ENTRIES),
    .GHR_BITS (GHR_BITS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bp_enable     (bp_enable),
    .f_valid       (f_valid),
    .f_pc          (f_pc),
    .br_pred_taken (br_pred_taken),
    .f_ghr         (f_ghr),
    .x_valid       (x_valid),
    .x_pc          (x_pc),
    .x_taken       (x_taken),
    .x_pred_taken  (x_pred_taken),
    .x_ghr         (x_ghr),
    .x_mispredict  (x_mispredict),
    .perf_branches (perf_branches),
    .perf_mispred  (perf_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    string               tag;
    logic                pred;
    logic [GHR_BITS-1:0] ghr;
    logic                mis;
    logic [CNT_W-1:0]    br;
    logic [CNT_W-1:0]    mp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int                  m_ctr[ENTRIES];
  logic [GHR_BITS-1:0] m_ghr;
  logic [CNT_W-1:0]    m_br;
  logic [CNT_W-1:0]    m_mp;

  function automatic int midx(input logic [31:0] pc, input logic [GHR_BITS-1:0] h);
    logic [4:0] b;
    b = pc[6:2];
    if (GSHARE) b = b ^ h;
    return int'(b);
  endfunction

  function automatic void model_reset();
    foreach (m_ctr[i]) m_ctr[i] = 1;
    m_ghr = '0;
    m_br  = '0;
    m_mp  = '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input bit fv, input logic [31:0] fpc, input bit en,
                      input bit xv, input logic [31:0] xpc, input bit xt, input bit xp);
    exp_t e;
    int   k;
    @(negedge clk);
    f_valid = fv; f_pc = fpc; bp_enable = en;
    x_valid = xv; x_pc = xpc; x_taken = xt; x_pred_taken = xp; x_ghr = m_ghr;
    e.tag  = tag;
    e.pred = en && fv && (m_ctr[midx(fpc, m_ghr)] >= 2);
    e.ghr  = GSHARE ? m_ghr : '0;
    e.mis  = xv && (xt != xp);
    e.br   = m_br;
    e.mp   = m_mp;
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_pred"}, 32'(br_pred_taken), 32'(e.pred));
      chk({e.tag, "_ghr"},  32'(f_ghr),         32'(e.ghr));
      chk({e.tag, "_mis"},  32'(x_mispredict),  32'(e.mis));
      chk({e.tag, "_br"},   32'(perf_branches), 32'(e.br));
      chk({e.tag, "_mp"},   32'(perf_mispred),  32'(e.mp));
    end
    $display("step %s fpc=%h pred=%0b ghr=%0h xv=%0b xpc=%h xt=%0b mis=%0b br=%0d mp=%0d",
             tag, fpc, br_pred_taken, f_ghr, xv, xpc, xt, x_mispredict, perf_branches, perf_mispred);
    if (xv) begin
      k = midx(xpc, m_ghr);
      if (xt && m_ctr[k] < 3) m_ctr[k]++;
      else if (!xt && m_ctr[k] > 0) m_ctr[k]--;
      m_ghr = {m_ghr[GHR_BITS-2:0], xt};
      m_br  = m_br + 1'b1;
      if (xt != xp) m_mp = m_mp + 1'b1;
    end
  endtask

  task automatic train(input string tag, input logic [31:0] pc, input bit t);
    step(tag, 1'b1, pc, 1'b1, 1'b1, pc, t, 1'b0);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc);
    step(tag, 1'b1, pc, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1. reset state
    lookup("reset_lookup", 32'h4000_0000);
    chk("reset_pred_const", 32'(br_pred_taken), 32'd0);

    // 2. basic training
    train("t10_a", 32'h4000_0010, 1'b1);
    train("t10_b", 32'h4000_0010, 1'b1);
    lookup("l10_st", 32'h4000_0010);
    train("n10_a", 32'h4000_0010, 1'b0);
    lookup("l10_wt", 32'h4000_0010);
    train("n10_b", 32'h4000_0010, 1'b0);
    lookup("l10_wnt", 32'h4000_0010);

    // 3. saturation
    for (int i = 0; i < 5; i++) train("sat_t", 32'h4000_0020, 1'b1);
    train("sat_t_n", 32'h4000_0020, 1'b0);
    lookup("sat_hi", 32'h4000_0020);
    for (int i = 0; i < 5; i++) train("sat_n", 32'h4000_0020, 1'b0);
    train("sat_n_t", 32'h4000_0020, 1'b1);
    lookup("sat_lo", 32'h4000_0020);

    // 4. aliasing (index wraps every 128 bytes)
    train("alias_a", 32'h4000_0004, 1'b1);
    train("alias_b", 32'h4000_0004, 1'b1);
    lookup("alias_84", 32'h4000_0084);

    // 5. same-cycle lookup/update, then bp_enable clamp
    train("same_cyc", 32'h4000_0030, 1'b1);
    lookup("same_next", 32'h4000_0030);
    for (int i = 0; i < 3; i++) train("en_t", 32'h4000_0040, 1'b1);
    step("en_off", 1'b1, 32'h4000_0040, 1'b0, 1'b1, 32'h4000_0040, 1'b0, 1'b1);
    lookup("en_on", 32'h4000_0040);

    // 6. async reset mid-sequence
    @(negedge clk);
    f_valid = 1'b1; f_pc = 32'h4000_0040; bp_enable = 1'b1;
    x_valid = 1'b1; x_taken = 1'b1; x_pred_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_pred", 32'(br_pred_taken), 32'd0);
    chk("rst_async_ghr",  32'(f_ghr),         32'd0);
    chk("rst_async_br",   32'(perf_branches), 32'd0);
    chk("rst_async_mp",   32'(perf_mispred),  32'd0);
    chk("rst_async_mis",  32'(x_mispredict),  32'd1);
    model_reset();
    @(negedge clk);
    x_valid = 1'b0;
    rst_n = 1'b1;

    // perf counters: 10 updates, 3 mispredicted
    for (int i = 0; i < 10; i++)
      step("perf_upd", 1'b0, 32'h0, 1'b1, 1'b1, 32'h4000_0050 + 32'(i * 4),
           bit'(i % 2), (i < 3) ? !bit'(i % 2) : bit'(i % 2));
    lookup("perf_10", 32'h4000_0050);
    chk("perf_branches_10", 32'(perf_branches), 32'd10);
    chk("perf_mispred_3",   32'(perf_mispred),  32'd3);
    for (int i = 0; i < 6; i++)
      step("perf_wrap", 1'b0, 32'h0, 1'b1, 1'b1, 32'h4000_0060, 1'b1, 1'b1);
    lookup("perf_16", 32'h4000_0060);
    chk("perf_branches_wrap", 32'(perf_branches), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
